// File: rtl/ahb_defs_pkg.sv
// Shared AHB encodings, slave FSM states and the sampled address-phase payload.
package ahb_defs_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

    // Address-phase fields held for the matching data phase.
    typedef struct packed {
        logic [29:0] word;
        logic [1:0]  offset;
        logic        write;
        logic [2:0]  size;
    } addr_phase_t;

    // Byte lanes touched by an aligned access of the given size at the given offset.
    function automatic logic [3:0] lane_mask(input logic [1:0] offset, input logic [2:0] size);
        logic [3:0] mask;
        mask = 4'b0000;
        case (size)
            HSIZE_BYTE: mask = 4'b0001 << offset;
            HSIZE_HALF: mask = offset[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: mask = 4'b1111;
            default:    mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave-side bus bundle.
interface ahb_sram_slave_if;

    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        output hreadyout, hresp, hrdata
    );

endinterface

// File: rtl/ahb_sram_mem.sv
// Word-organised SRAM with byte-enabled synchronous write and combinational read.
module ahb_sram_mem #(
    parameter  int unsigned DEPTH = 256,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    wbe,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata_c
);

    logic [31:0] mem [DEPTH];

    // Byte-lane write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wbe[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with configurable wait states, error response and write-to-read forwarding.
module ahb_sram_slave
    import ahb_defs_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic             hclk,
    input  logic             hreset,
    ahb_sram_slave_if.slave  bus
);

    localparam int unsigned AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CW      = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int unsigned WS_LAST = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

    state_e        state;
    state_e        nxt;
    logic [CW-1:0] wait_cnt;
    addr_phase_t   aph_q;
    addr_phase_t   aph_d;
    logic          accept;
    logic          xfer_err;
    logic          commit_we;
    logic [3:0]    be_q;
    logic [29:0]   rd_word;
    logic          rd_is_read;
    logic [31:0]   mem_rdata_c;
    logic [31:0]   rdata_fwd;
    logic          hreadyout_q;
    logic          hresp_q;
    logic [31:0]   hrdata_q;
    logic          bus_unused;

    assign bus_unused = ^{bus.hburst, bus.htrans[0]};

    // Address-phase decode: acceptance, error classification and next state.
    always_comb begin
        accept   = (state inside {ST_IDLE, ST_DATA, ST_ERR2}) & bus.hsel & bus.hready & bus.htrans[1];
        xfer_err = (bus.hsize > 3'd2)
                 | ((bus.hsize == 3'd1) & bus.haddr[0])
                 | ((bus.hsize == 3'd2) & (bus.haddr[1:0] != 2'b00))
                 | ({2'b00, bus.haddr[31:2]} >= 32'(MEM_DEPTH));
        aph_d.word   = bus.haddr[31:2];
        aph_d.offset = bus.haddr[1:0];
        aph_d.write  = bus.hwrite;
        aph_d.size   = bus.hsize;

        nxt = state;
        case (state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept) begin
                    nxt = xfer_err ? ST_ERR1 : ((WAIT_STATES > 0) ? ST_WAIT : ST_DATA);
                end else begin
                    nxt = ST_IDLE;
                end
            end
            ST_WAIT: if (wait_cnt == CW'(WS_LAST)) nxt = ST_DATA;
            ST_ERR1: nxt = ST_ERR2;
            default: nxt = ST_IDLE;
        endcase
    end

    // Read source for the coming data phase, merged with a write retiring on the same edge.
    always_comb begin
        be_q       = lane_mask(aph_q.offset, aph_q.size);
        commit_we  = (state == ST_DATA) & aph_q.write & ~hreset;
        rd_word    = accept ? bus.haddr[31:2] : aph_q.word;
        rd_is_read = accept ? ~bus.hwrite : ~aph_q.write;
        rdata_fwd  = mem_rdata_c;
        if (commit_we && (aph_q.word == rd_word)) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) rdata_fwd[8*i +: 8] = bus.hwdata[8*i +: 8];
            end
        end
    end

    // FSM state, wait counter, sampled address and registered bus responses.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            aph_q       <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            hrdata_q    <= '0;
        end else begin
            state <= nxt;
            if (accept) aph_q <= aph_d;
            wait_cnt    <= ((state == ST_WAIT) && (nxt == ST_WAIT)) ? wait_cnt + CW'(1) : '0;
            hreadyout_q <= !((nxt == ST_WAIT) || (nxt == ST_ERR1));
            hresp_q     <= ((nxt == ST_ERR1) || (nxt == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
            hrdata_q    <= ((nxt == ST_DATA) && rd_is_read) ? rdata_fwd : '0;
        end
    end

    ahb_sram_mem #(.DEPTH(MEM_DEPTH)) u_mem (
        .clk     (hclk),
        .we      (commit_we),
        .waddr   (aph_q.word[AW-1:0]),
        .wbe     (be_q),
        .wdata   (bus.hwdata),
        .raddr   (rd_word[AW-1:0]),
        .rdata_c (mem_rdata_c)
    );

    assign bus.hreadyout = hreadyout_q;
    assign bus.hresp     = hresp_q;
    assign bus.hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench: zero-wait slave driven with pipelined sequences, 3-wait slave with single transfers.
module tb_ahb_sram_slave;
    import ahb_defs_pkg::*;

    localparam int unsigned KIND_XFER = 0;
    localparam int unsigned KIND_BUSY = 1;
    localparam int unsigned KIND_IDLE = 2;

    logic hclk = 1'b0;
    logic hreset;
    always #5 hclk = ~hclk;

    ahb_sram_slave_if bus0 ();
    ahb_sram_slave_if bus1 ();
    assign bus0.hready = bus0.hreadyout;
    assign bus1.hready = bus1.hreadyout;

    ahb_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (.hclk(hclk), .hreset(hreset), .bus(bus0));
    ahb_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(3)) dut1 (.hclk(hclk), .hreset(hreset), .bus(bus1));

    typedef struct {
        int unsigned kind;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        bit          err;
        bit          rd;
        logic [31:0] rdata;
    } exp_t;

    xfer_t       stim_q [$];
    exp_t        sb_q [$];
    logic [31:0] sb1_q [$];
    logic [31:0] model0 [256];
    int          total = 0;
    int          bad = 0;
    int          stalls;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_err(input logic [31:0] a, input logic [2:0] s);
        return (s > 3'd2) || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00)
            || (a[31:2] >= 30'd256);
    endfunction

    function automatic logic [3:0] lanes(input logic [31:0] a, input logic [2:0] s);
        logic [3:0] m;
        m = 4'b0000;
        if (s == 3'd0) m[a[1:0]] = 1'b1;
        else if (s == 3'd1) m = a[1] ? 4'b1100 : 4'b0011;
        else m = 4'b1111;
        return m;
    endfunction

    task automatic add(input int unsigned kind, input bit wr, input logic [31:0] a, input logic [2:0] s,
                       input logic [1:0] tr, input logic [31:0] d);
        xfer_t x;
        x.kind = kind; x.wr = wr; x.addr = a; x.size = s; x.trans = tr;
        x.burst = (tr == HTRANS_SEQ || kind == KIND_BUSY) ? 3'd3 : 3'd0;
        x.wdata = d;
        stim_q.push_back(x);
    endtask

    // Predict the response of one accepted transfer and apply it to the memory model.
    task automatic predict(input xfer_t x);
        exp_t       e;
        logic [3:0] m;
        int         idx;
        e.err = is_err(x.addr, x.size);
        e.rd = !x.wr;
        e.rdata = 32'h0;
        if (!e.err) begin
            idx = int'(x.addr[9:2]);
            if (x.wr) begin
                m = lanes(x.addr, x.size);
                for (int i = 0; i < 4; i++)
                    if (m[i]) model0[idx][8*i +: 8] = x.wdata[8*i +: 8];
            end else begin
                e.rdata = model0[idx];
            end
        end
        sb_q.push_back(e);
    endtask

    // Pipelined driver/monitor for the zero-wait slave; counts stall cycles.
    task automatic run_bus0();
        xfer_t cur;
        xfer_t dp;
        bit    dp_v;
        exp_t  e;
        int    guard;
        dp_v = 1'b0;
        stalls = 0;
        guard = 0;
        while ((stim_q.size() > 0 || dp_v) && guard < 1000) begin
            guard++;
            @(posedge hclk); #1;
            if (stim_q.size() > 0) begin
                cur = stim_q[0];
                bus0.hsel   = 1'b1;
                bus0.htrans = (cur.kind == KIND_XFER) ? cur.trans :
                              ((cur.kind == KIND_BUSY) ? HTRANS_BUSY : HTRANS_IDLE);
                bus0.haddr  = cur.addr;
                bus0.hwrite = cur.wr;
                bus0.hsize  = cur.size;
                bus0.hburst = cur.burst;
            end else begin
                bus0.hsel   = 1'b0;
                bus0.htrans = HTRANS_IDLE;
            end
            bus0.hwdata = dp_v ? dp.wdata : 32'h0;
            @(negedge hclk);
            if (!bus0.hreadyout) stalls++;
            if (dp_v) begin
                if (bus0.hreadyout) begin
                    e = sb_q.pop_front();
                    check("resp", 32'(bus0.hresp), 32'(e.err));
                    if (e.rd || e.err) check("rdata", bus0.hrdata, e.rdata);
                    dp_v = 1'b0;
                end else if (sb_q.size() > 0) begin
                    check("stall_resp", 32'(bus0.hresp), 32'(sb_q[0].err));
                end
            end else begin
                check("idle_ready", 32'(bus0.hreadyout), 32'h1);
                check("idle_resp", 32'(bus0.hresp), 32'h0);
            end
            if (bus0.hreadyout && stim_q.size() > 0) begin
                cur = stim_q.pop_front();
                if (cur.kind == KIND_XFER) begin
                    predict(cur);
                    dp = cur;
                    dp_v = 1'b1;
                end
            end
        end
        check("run_timeout", 32'(stim_q.size()) + 32'(dp_v), 32'h0);
        stim_q.delete();
    endtask

    // One non-overlapped word transfer on the 3-wait slave.
    task automatic b1_xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           output int st, output logic [31:0] rd, output logic rsp);
        @(posedge hclk); #1;
        bus1.hsel = 1'b1; bus1.htrans = HTRANS_NONSEQ; bus1.haddr = a;
        bus1.hwrite = wr; bus1.hsize = HSIZE_WORD;
        @(posedge hclk); #1;
        bus1.hsel = 1'b0; bus1.htrans = HTRANS_IDLE; bus1.hwdata = d;
        st = 0; rd = 32'h0; rsp = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge hclk);
            if (bus1.hreadyout) begin
                rd = bus1.hrdata;
                rsp = bus1.hresp;
                break;
            end
            st++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st;
        logic [31:0] rd;
        logic        rsp;

        {bus0.hsel, bus0.haddr, bus0.htrans, bus0.hwrite, bus0.hsize, bus0.hburst, bus0.hwdata} = '0;
        {bus1.hsel, bus1.haddr, bus1.htrans, bus1.hwrite, bus1.hsize, bus1.hburst, bus1.hwdata} = '0;
        hreset = 1'b1;
        repeat (2) @(posedge hclk);
        #1 hreset = 1'b0;
        @(negedge hclk);
        check("rst_ready0", 32'(bus0.hreadyout), 32'h1);
        check("rst_resp0", 32'(bus0.hresp), 32'h0);
        check("rst_rdata0", bus0.hrdata, 32'h0);
        check("rst_ready1", 32'(bus1.hreadyout), 32'h1);
        check("rst_resp1", 32'(bus1.hresp), 32'h0);
        check("rst_rdata1", bus1.hrdata, 32'h0);

        // Word write then read, no stalls.
        add(KIND_XFER, 1, 32'h10, 3'd2, HTRANS_NONSEQ, 32'hDEADBEEF);
        add(KIND_XFER, 0, 32'h10, 3'd2, HTRANS_NONSEQ, 32'h0);
        run_bus0();
        check("stalls_word", 32'(stalls), 32'h0);

        // Byte and half-word lane writes assembled into words.
        add(KIND_XFER, 1, 32'h20, 3'd0, HTRANS_NONSEQ, {4{8'h11}});
        add(KIND_XFER, 1, 32'h21, 3'd0, HTRANS_NONSEQ, {4{8'h22}});
        add(KIND_XFER, 1, 32'h22, 3'd0, HTRANS_NONSEQ, {4{8'h33}});
        add(KIND_XFER, 1, 32'h23, 3'd0, HTRANS_NONSEQ, {4{8'h44}});
        add(KIND_IDLE, 0, 32'h0, 3'd0, HTRANS_IDLE, 32'h0);
        add(KIND_XFER, 0, 32'h20, 3'd2, HTRANS_NONSEQ, 32'h0);
        add(KIND_XFER, 1, 32'h24, 3'd2, HTRANS_NONSEQ, 32'h01234567);
        add(KIND_XFER, 1, 32'h26, 3'd1, HTRANS_NONSEQ, {2{16'hBEEF}});
        add(KIND_XFER, 0, 32'h24, 3'd2, HTRANS_NONSEQ, 32'h0);
        add(KIND_XFER, 0, 32'h26, 3'd1, HTRANS_NONSEQ, 32'h0);
        run_bus0();
        check("stalls_bytes", 32'(stalls), 32'h0);

        // Error responses leave memory untouched; IDLE with a bad address is not an error.
        add(KIND_XFER, 1, 32'h00, 3'd2, HTRANS_NONSEQ, 32'hCAFEF00D);
        add(KIND_XFER, 1, 32'h02, 3'd2, HTRANS_NONSEQ, 32'hFFFFFFFF);
        add(KIND_XFER, 1, 32'h400, 3'd2, HTRANS_NONSEQ, 32'hFFFFFFFF);
        add(KIND_XFER, 1, 32'h01, 3'd1, HTRANS_NONSEQ, 32'hFFFFFFFF);
        add(KIND_XFER, 0, 32'h00, 3'd3, HTRANS_NONSEQ, 32'h0);
        add(KIND_IDLE, 0, 32'h403, 3'd7, HTRANS_IDLE, 32'h0);
        add(KIND_XFER, 0, 32'h00, 3'd2, HTRANS_NONSEQ, 32'h0);
        run_bus0();
        check("stalls_err", 32'(stalls), 32'h4);

        // Forwarded read-after-write and INCR4 bursts, one with a BUSY beat.
        add(KIND_XFER, 1, 32'h40, 3'd2, HTRANS_NONSEQ, 32'h5A5A5A5A);
        add(KIND_XFER, 0, 32'h40, 3'd2, HTRANS_NONSEQ, 32'h0);
        add(KIND_XFER, 1, 32'h50, 3'd2, HTRANS_NONSEQ, 32'hA0000000);
        add(KIND_XFER, 1, 32'h54, 3'd2, HTRANS_SEQ, 32'hA1111111);
        add(KIND_XFER, 1, 32'h58, 3'd2, HTRANS_SEQ, 32'hA2222222);
        add(KIND_XFER, 1, 32'h5C, 3'd2, HTRANS_SEQ, 32'hA3333333);
        add(KIND_XFER, 0, 32'h50, 3'd2, HTRANS_NONSEQ, 32'h0);
        add(KIND_XFER, 0, 32'h54, 3'd2, HTRANS_SEQ, 32'h0);
        add(KIND_BUSY, 0, 32'h58, 3'd2, HTRANS_BUSY, 32'h0);
        add(KIND_XFER, 0, 32'h58, 3'd2, HTRANS_SEQ, 32'h0);
        add(KIND_XFER, 0, 32'h5C, 3'd2, HTRANS_SEQ, 32'h0);
        run_bus0();
        check("stalls_burst", 32'(stalls), 32'h0);
        check("sb_empty", 32'(sb_q.size()), 32'h0);

        // Three wait states per transfer on the second slave.
        sb1_q.push_back(32'h0);
        b1_xfer(1, 32'h08, 32'h11112222, st, rd, rsp);
        check("ws3_wr_stalls", 32'(st), 32'h3);
        check("ws3_wr_resp", 32'(rsp), 32'h0);
        void'(sb1_q.pop_front());
        sb1_q.push_back(32'h11112222);
        b1_xfer(0, 32'h08, 32'h0, st, rd, rsp);
        check("ws3_rd_stalls", 32'(st), 32'h3);
        check("ws3_rd_resp", 32'(rsp), 32'h0);
        check("ws3_rd_data", rd, sb1_q.pop_front());

        // Reset during the wait phase of a write abandons it.
        @(posedge hclk); #1;
        bus1.hsel = 1'b1; bus1.htrans = HTRANS_NONSEQ; bus1.haddr = 32'h08;
        bus1.hwrite = 1'b1; bus1.hsize = HSIZE_WORD;
        @(posedge hclk); #1;
        bus1.hsel = 1'b0; bus1.htrans = HTRANS_IDLE; bus1.hwdata = 32'h99999999;
        @(negedge hclk);
        check("mid_wait_ready", 32'(bus1.hreadyout), 32'h0);
        hreset = 1'b1;
        @(posedge hclk); #1;
        hreset = 1'b0;
        @(negedge hclk);
        check("mid_rst_ready", 32'(bus1.hreadyout), 32'h1);
        check("mid_rst_resp", 32'(bus1.hresp), 32'h0);
        sb1_q.push_back(32'h11112222);
        b1_xfer(0, 32'h08, 32'h0, st, rd, rsp);
        check("mid_rst_keep", rd, sb1_q.pop_front());
        check("mid_rst_stalls", 32'(st), 32'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
